psum_collector: RTL
===================

# psum_collector

Back-end consumer for the multi-lane convolution core's partial-sum stream. It reduces the four per-cycle lane partial sums and accumulates them across input-channel groups until the core flags the last group. It then saturates the result to 8 bits and writes one output-feature-map element per output pixel into the output BRAM in channel-major order. It also checks the core's `img_end` against its own pixel/channel counters and reports completion.

## Interface
Parameters:
- `PSUM_W`, default 8: signed width of each lane partial sum.
- `ACC_W`, default 20: signed accumulator width.
- `ADDR_W`, default 16: output BRAM address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `start`, in, 1: one-cycle pulse that arms the collector for a new layer.
- `WxW_out`, in, 16: output pixels per channel (width × width); sampled on `start`.
- `no_channel_out`, in, 11: number of output channels to collect; sampled on `start`.
- `psum_valid`, in, 1: lane partial sums are valid this cycle.
- `psum_0` … `psum_3`, in, `PSUM_W`: signed lane partial sums.
- `channel_end`, in, 1: qualified by `psum_valid`; this beat is the last input-channel group of the current output element.
- `img_end`, in, 1: qualified by `psum_valid` and `channel_end`; the core's last element of the layer.
- `wr_en`, out, 1: output BRAM write strobe.
- `wr_addr`, out, `ADDR_W`: write address, `oc*WxW_out + pix`.
- `wr_data`, out, 8: saturated result.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse when the final element is written.
- `err`, out, 1: sticky protocol mismatch flag.

## Operation
State machine:
- **IDLE** → RUN on `start`.
  - Latches `WxW_out` and `no_channel_out`.
  - Clears `pix`, `oc`, the accumulator and `err`.
- **RUN**:
  - Each valid beat forms `lane_sum = psum_0+psum_1+psum_2+psum_3`, sign-extended to `PSUM_W+2`.
  - `lane_sum` is added into `acc`.
  - On a `channel_end` beat the element is committed: `acc + lane_sum` is written, then `acc` is cleared.
  - Counters advance: `pix++`; if `pix == WxW_out-1`, `pix` wraps to 0 and `oc++`.
- **DONE**: one cycle, `done=1`, then → IDLE.
  - Entered on the commit of the last element: `oc == no_channel_out-1` and `pix == WxW_out-1`.

Arithmetic:
- All sums are signed two's complement.
- Accumulator overflow wraps at `ACC_W`; no overflow detection is required.
- Output saturation: values > 127 → 127; values < −128 → −128.

Boundary conditions:
- `img_end` on a commit that is not the last element: set `err`, write normally, go to DONE.
- Last element committed without `img_end`: set `err`, still go to DONE.
- `channel_end` or `img_end` without `psum_valid`: ignored.
- `psum_valid` in IDLE or DONE: ignored; no accumulation.
- `start` in RUN or DONE: ignored.
- `WxW_out == 0` or `no_channel_out == 0` at `start`: go directly to DONE and set `err`; no writes.
- Reset mid-operation: immediately return to IDLE; all outputs and state go to 0; no write is emitted.

## Timing
- Reset value of every output is 0.
- Two-stage pipeline:
  - Cycle t: beat sampled.
  - Cycle t+1: `lane_sum` registered.
  - Cycle t+2: `wr_en`, `wr_addr` and `wr_data` are registered outputs, valid for exactly one cycle.
- Accepts one beat per cycle with no back-pressure; back-to-back `channel_end` beats give back-to-back writes.
- `done` is asserted in the same cycle as the final `wr_en`.
- `busy` falls in the cycle after `done`.
- Because of the pipeline, a new `start` takes effect at the earliest 1 cycle after `done`.

## Configuration
- `PSUM_COLLECTOR_RELU_EN` defined: ReLU is applied before saturation (negative results write 0).
- Undefined: signed saturation only.

## Structure
- Shared package `cnn_pkg` holds:
  - `PSUM_W` and the output data width (8).
  - The state enum `{IDLE, RUN, DONE}`.
  - The saturate/ReLU function.
- One sub-module, `psum_lane_adder`: registered 4-input signed adder producing `lane_sum`.

## Test plan
- `WxW_out=9`, `no_channel_out=2`, 2 beats per element, all lanes = 1:
  - 18 writes, each data 8, addresses 0..17.
  - `done` coincides with the write to address 17; `err=0`.
- Lanes = 100 each, 2 beats per element:
  - Data 127 (saturated).
  - Lanes = −100: data −128, or 0 with `PSUM_COLLECTOR_RELU_EN`.
- Mixed signs (`psum_0=5`, `psum_1=-3`, `psum_2=0`, `psum_3=-4`), single-beat elements: data −2.
  - Verify `wr_en` 2 cycles after the beat.
- `img_end` asserted on element 5 of 9, `no_channel_out=1`:
  - `err=1`, `done` pulses with write 5, return to IDLE.
- Reset asserted mid-RUN after 4 writes:
  - All outputs 0 asynchronously; no further writes.
  - A new `start` restarts at address 0.
- `psum_valid` pulses while in IDLE, and a second `start` during RUN:
  - No writes from the idle beats.
  - Counters unaffected by the second `start`.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution back-end.
// PSUM_COLLECTOR_RELU_EN selects ReLU ahead of output saturation.
package cnn_pkg;

    localparam int PSUM_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [DATA_W-1:0] sat_out(input logic signed [31:0] v);
        logic [DATA_W-1:0] r;
        r = v[DATA_W-1:0];
        if (v > 32'sd127) r = 8'h7f;
        if (v < -32'sd128) r = 8'h80;
`ifdef PSUM_COLLECTOR_RELU_EN
        if (v < 32'sd0) r = '0;
`endif
        return r;
    endfunction

endpackage

// File: rtl/psum_lane_adder.sv
// First pipeline stage: registered sum of the four lane partial sums
// together with the qualified beat flags.
module psum_lane_adder #(
    parameter int PSUM_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     valid_i,
    input  logic                     ce_i,
    input  logic                     ie_i,
    input  logic signed [PSUM_W-1:0] p0_i,
    input  logic signed [PSUM_W-1:0] p1_i,
    input  logic signed [PSUM_W-1:0] p2_i,
    input  logic signed [PSUM_W-1:0] p3_i,
    output logic signed [PSUM_W+1:0] sum_o,
    output logic                     valid_o,
    output logic                     ce_o,
    output logic                     ie_o
);

    logic signed [PSUM_W+1:0] sum_d, sum_q;
    logic valid_d, ce_d, ie_d;
    logic valid_q, ce_q, ie_q;

    always_comb begin
        sum_d = (PSUM_W+2)'(p0_i) + (PSUM_W+2)'(p1_i)
              + (PSUM_W+2)'(p2_i) + (PSUM_W+2)'(p3_i);
        valid_d = valid_i & en_i;
        ce_d = ce_i & valid_d;
        ie_d = ie_i & ce_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            ce_q    <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
            ce_q    <= ce_d;
            ie_q    <= ie_d;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign ce_o    = ce_q;
    assign ie_o    = ie_q;

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: accumulate, saturate, write channel-major OFM.
// Define PSUM_COLLECTOR_RELU_EN to clamp negative results to 0.
module psum_collector #(
    parameter int PSUM_W = cnn_pkg::PSUM_W,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       WxW_out,
    input  logic [10:0]       no_channel_out,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_0,
    input  logic [PSUM_W-1:0] psum_1,
    input  logic [PSUM_W-1:0] psum_2,
    input  logic [PSUM_W-1:0] psum_3,
    input  logic              channel_end,
    input  logic              img_end,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import cnn_pkg::*;

    state_e state_d, state_q;
    logic [15:0] wxw_d, wxw_q, pix_d, pix_q;
    logic [10:0] nch_d, nch_q, oc_d, oc_q;
    logic [ADDR_W-1:0] addr_d, addr_q, wr_addr_d, wr_addr_q;
    logic signed [ACC_W-1:0] acc_d, acc_q, sum;
    logic [7:0] wr_data_d, wr_data_q;
    logic wr_en_d, wr_en_q, err_d, err_q;
    logic signed [PSUM_W+1:0] lane_sum;
    logic lv, lce, lie, last;

    psum_lane_adder #(.PSUM_W(PSUM_W)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q == RUN),
        .valid_i (psum_valid),
        .ce_i    (channel_end),
        .ie_i    (img_end),
        .p0_i    (psum_0),
        .p1_i    (psum_1),
        .p2_i    (psum_2),
        .p3_i    (psum_3),
        .sum_o   (lane_sum),
        .valid_o (lv),
        .ce_o    (lce),
        .ie_o    (lie)
    );

    assign sum  = acc_q + ACC_W'(lane_sum);
    assign last = (oc_q == nch_q - 11'd1) && (pix_q == wxw_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        wxw_d     = wxw_q;
        nch_d     = nch_q;
        pix_d     = pix_q;
        oc_d      = oc_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wxw_d  = WxW_out;
                    nch_d  = no_channel_out;
                    pix_d  = '0;
                    oc_d   = '0;
                    addr_d = '0;
                    acc_d  = '0;
                    err_d  = 1'b0;
                    state_d = RUN;
                    if (WxW_out == 16'd0 || no_channel_out == 11'd0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (lv && !lce) begin
                    acc_d = sum;
                end else if (lv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = sat_out(32'(sum));
                    acc_d     = '0;
                    addr_d    = addr_q + ADDR_W'(1);
                    if (pix_q == wxw_q - 16'd1) begin
                        pix_d = '0;
                        oc_d  = oc_q + 11'd1;
                    end else begin
                        pix_d = pix_q + 16'd1;
                    end
                    // Either end marker terminates; disagreement is a protocol error.
                    if (last || lie) begin
                        state_d = DONE;
                        if (last != lie) err_d = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wxw_q     <= '0;
            nch_q     <= '0;
            pix_q     <= '0;
            oc_q      <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wxw_q     <= wxw_d;
            nch_q     <= nch_d;
            pix_q     <= pix_d;
            oc_q      <= oc_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;

endmodule
